// File: rtl/watchdog_supervisor_if.sv
// Supervisor <-> environment signal bundle: configuration and slave-board pins.
// There is no valid/ready handshake here. Every signal is a level. The master
// drives cfg, fault_clear and the raw slave returns; the slave (supervisor)
// drives the lines to the board and the status word.
interface watchdog_supervisor_if;
  logic [3:0]  supervisor_cfg;
  logic        fault_clear;
  logic        reset_ack;
  logic        alive_signal;
  logic        watchdog;
  logic        trigger;
  logic        instant_reset;
  logic        fault;
  logic [31:0] supervisor_sts;
  logic [1:0]  state_dbg;

  modport master (
    output supervisor_cfg, fault_clear, reset_ack, alive_signal,
    input  watchdog, trigger, instant_reset, fault, supervisor_sts, state_dbg
  );

  modport slave (
    input  supervisor_cfg, fault_clear, reset_ack, alive_signal,
    output watchdog, trigger, instant_reset, fault, supervisor_sts, state_dbg
  );
endinterface

// File: rtl/watchdog_supervisor.sv
// Drives the watchdog heartbeat, trigger and instant_reset lines to a slave board.
// Faults on a missing watchdog echo or a missing alive pulse.
module watchdog_supervisor #(
  parameter int unsigned WATCHDOG_TOGGLE_CYCLES = 1250000,
  parameter int unsigned ACK_TIMEOUT_CYCLES     = 1250,
  parameter int unsigned ALIVE_TIMEOUT_CYCLES   = 15000000
) (
  input  logic                 clk,
  input  logic                 peripheral_reset,
  watchdog_supervisor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [27:0] TOG_LAST  = 28'(WATCHDOG_TOGGLE_CYCLES - 1);
  localparam logic [27:0] ACK_MAX   = 28'(ACK_TIMEOUT_CYCLES);
  localparam logic [27:0] ALIVE_MAX = 28'(ALIVE_TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        ack_meta_q, ack_s_q;
  logic        alive_meta_q, alive_s_q;
  logic [27:0] tog_cnt_q, tog_cnt_d;
  logic [27:0] ack_cnt_q, ack_cnt_d;
  logic [27:0] alive_cnt_q, alive_cnt_d;
  logic [15:0] toggle_count_q, toggle_count_d;
  logic        watchdog_q, watchdog_d;
  logic        ack_ok_q, ack_ok_d;
  logic        ack_fault_q, ack_fault_d;
  logic        alive_fault_q, alive_fault_d;
  logic        trigger_q, trigger_d;
  logic        instant_reset_q, instant_reset_d;

  logic hb_en, al_en, active, toggle, alive_rise;
  logic ack_fault_set, alive_fault_set, new_fault;

  assign hb_en      = bus.supervisor_cfg[0];
  assign al_en      = bus.supervisor_cfg[1];
  assign active     = (state_q != ST_IDLE);
  assign toggle     = (state_q == ST_RUN) && hb_en && (tog_cnt_q == TOG_LAST);
  // Edge seen one stage early so the counter clear lands on the cycle alive_s rises.
  assign alive_rise = alive_meta_q & ~alive_s_q;

  // In FAULT the counters are frozen, so a persisting mismatch or a dead alive
  // line keeps re-asserting the fault and blocks fault_clear.
  assign ack_fault_set   = active && hb_en && (ack_cnt_q == ACK_MAX) && !ack_ok_q
                           && (ack_s_q != watchdog_q);
  assign alive_fault_set = active && al_en && (alive_cnt_q == ALIVE_MAX);
  assign new_fault       = ack_fault_set | alive_fault_set;

  always_comb begin
    state_d         = state_q;
    tog_cnt_d       = tog_cnt_q;
    ack_cnt_d       = ack_cnt_q;
    alive_cnt_d     = alive_cnt_q;
    toggle_count_d  = toggle_count_q;
    watchdog_d      = watchdog_q;
    ack_ok_d        = ack_ok_q;
    ack_fault_d     = ack_fault_q | ack_fault_set;
    alive_fault_d   = alive_fault_q | alive_fault_set;

    case (state_q)
      ST_IDLE: begin
        if (hb_en || al_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (new_fault)            state_d = ST_FAULT;
        else if (!hb_en && !al_en) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (bus.fault_clear && !new_fault) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.fault_clear && !new_fault) begin
      ack_fault_d   = 1'b0;
      alive_fault_d = 1'b0;
    end

    case (state_q)
      ST_RUN: begin
        if (hb_en) begin
          if (toggle) begin
            tog_cnt_d      = '0;
            watchdog_d     = ~watchdog_q;
            toggle_count_d = toggle_count_q + 16'd1;
            ack_cnt_d      = '0;
            ack_ok_d       = 1'b0;
          end else begin
            tog_cnt_d = tog_cnt_q + 28'd1;
            if (ack_cnt_q != ACK_MAX) ack_cnt_d = ack_cnt_q + 28'd1;
            ack_ok_d  = ack_ok_q | (ack_s_q == watchdog_q);
          end
        end
        if (al_en) begin
          if (alive_rise)                  alive_cnt_d = '0;
          else if (alive_cnt_q != ALIVE_MAX) alive_cnt_d = alive_cnt_q + 28'd1;
        end
      end
      ST_FAULT: begin
        if (al_en && alive_rise) alive_cnt_d = '0;
      end
      default: begin
        // IDLE: everything restarts from zero on the next RUN entry; watchdog holds.
        tog_cnt_d   = '0;
        ack_cnt_d   = '0;
        alive_cnt_d = '0;
        ack_ok_d    = 1'b0;
      end
    endcase

    trigger_d       = bus.supervisor_cfg[2] && (state_d == ST_RUN);
    instant_reset_d = bus.supervisor_cfg[3] && (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (peripheral_reset) begin
      state_q         <= ST_IDLE;
      ack_meta_q      <= 1'b0;
      ack_s_q         <= 1'b0;
      alive_meta_q    <= 1'b0;
      alive_s_q       <= 1'b0;
      tog_cnt_q       <= '0;
      ack_cnt_q       <= '0;
      alive_cnt_q     <= '0;
      toggle_count_q  <= '0;
      watchdog_q      <= 1'b0;
      ack_ok_q        <= 1'b0;
      ack_fault_q     <= 1'b0;
      alive_fault_q   <= 1'b0;
      trigger_q       <= 1'b0;
      instant_reset_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ack_meta_q      <= bus.reset_ack;
      ack_s_q         <= ack_meta_q;
      alive_meta_q    <= bus.alive_signal;
      alive_s_q       <= alive_meta_q;
      tog_cnt_q       <= tog_cnt_d;
      ack_cnt_q       <= ack_cnt_d;
      alive_cnt_q     <= alive_cnt_d;
      toggle_count_q  <= toggle_count_d;
      watchdog_q      <= watchdog_d;
      ack_ok_q        <= ack_ok_d;
      ack_fault_q     <= ack_fault_d;
      alive_fault_q   <= alive_fault_d;
      trigger_q       <= trigger_d;
      instant_reset_q <= instant_reset_d;
    end
  end

  assign bus.watchdog       = watchdog_q;
  assign bus.trigger        = trigger_q;
  assign bus.instant_reset  = instant_reset_q;
  assign bus.fault          = (state_q == ST_FAULT);
  assign bus.state_dbg      = state_q;
  assign bus.supervisor_sts = {toggle_count_q, 7'd0, instant_reset_q, trigger_q,
                               alive_s_q, ack_s_q, watchdog_q, alive_fault_q,
                               ack_fault_q, (state_q == ST_FAULT), (state_q == ST_RUN)};

endmodule
